parking_gate_arbiter: RTL and testbench
=======================================

# parking_gate_arbiter

Shares one occupancy counter between two parking-lot gates. Each gate's car-detection FSM delivers one-cycle `enter`/`exit` pulses. This block queues those pulses per gate and enforces lot capacity and non-negative occupancy. It serializes them into at most one `incr` or `decr` strobe per cycle for the downstream counter and HEX display logic, and keeps a registered occupancy mirror used for admission decisions and gate lamps.

## Interface
- `CAPACITY`, 16: maximum occupancy; `full` when `count == CAPACITY`.
- `WIDTH`, 5: width of `count`; must hold `CAPACITY`.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `enter_req`  in  2  bit g = one-cycle entry pulse from gate g's detection FSM.
- `exit_req`  in  2  bit g = one-cycle exit pulse from gate g's detection FSM.
- `incr`  out  1  one-cycle strobe to occupancy counter (+1).
- `decr`  out  1  one-cycle strobe to occupancy counter (−1).
- `grant_gate`  out  1  gate index serviced by the current strobe; holds its last value when idle.
- `count`  out  WIDTH  occupancy mirror; matches the downstream counter.
- `full`  out  1  `count == CAPACITY`.
- `empty`  out  1  `count == 0`.
- `entry_allow`  out  1  `count + total pending entries < CAPACITY`; drives gate "space available" lamps.
- `reject`  out  1  one-cycle pulse: an entry was refused for lack of capacity.
- `underflow`  out  1  sticky: an exit was refused because occupancy would go negative.
- `overflow`  out  1  sticky: an event was dropped because its pending queue was saturated.

## Operation
- Per gate g: `ent_pend[g]` and `ext_pend[g]`, 2-bit saturating counters (max 3).
- **Admission** is evaluated each cycle on start-of-cycle register values.
  - Entries are checked gate 0 first, then gate 1.
  - An entry is accepted iff `count + Σent_pend + (entries already accepted this cycle) < CAPACITY`.
  - A refused entry is not queued and pulses `reject` once; two refusals in one cycle still give a single pulse.
  - Exits are checked gate 0 first, then gate 1.
  - An exit is accepted iff `count − Σext_pend − (exits already accepted this cycle) ≥ 1`.
  - A refused exit sets `underflow`.
  - An accepted event arriving when its queue is at 3 is dropped and sets `overflow`.
- **Service arbiter** grants at most one per cycle.
  - Exits are granted before entries, since they free space.
  - Within a class, round-robin pointer `rr` picks the gate: start at gate `rr`, take the first with nonzero pend.
  - `rr` flips to the other gate after every grant.
- **Grant effects**, all at the same clock edge:
  - the granted pend decrements;
  - `count` ±1;
  - `incr`/`decr` and `grant_gate` register.
- A pend counter accepting and being granted in the same cycle nets to no change.
- **States:**
  - IDLE: all pends zero.
  - SERVE_EXIT: any `ext_pend` nonzero.
  - SERVE_ENTRY: exits empty, entries pending.
  - Transitions are re-evaluated every cycle; there is no multi-cycle lockout.
- **Invariant:** `0 ≤ count ≤ CAPACITY` at all times. `count + Σent_pend ≤ CAPACITY`.
- `full`, `empty` and `entry_allow` are combinational from registers.
- `incr` and `decr` are never both high.

## Timing
- Reset values:
  - `incr=0`, `decr=0`, `grant_gate=0`, `count=0`;
  - `full=0`, `empty=1`, `entry_allow=1`;
  - `reject=0`, `underflow=0`, `overflow=0`;
  - all pends 0, `rr=0`.
- Reset mid-queue discards all pending events. No strobe occurs in the cycle after reset. Reset dominates simultaneous requests.
- Latency with an empty queue: pulse in cycle N → pend captured at end of N. The strobe is granted from the captured pend at the end of N+1, so `incr`/`decr` is high, with updated `count`, in cycle N+2.
- `reject` is high in cycle N+1 for a refused entry pulsed in cycle N. `underflow` and `overflow` set at end of N and stay high until reset.
- Throughput: one strobe per cycle. Back-to-back pending events give consecutive strobes with no bubble.
- Both gates entering in cycle N with queues empty:
  - `incr` in N+2 with `grant_gate=rr`;
  - `incr` in N+3 with the other gate.

## Test plan
- Reset, then `enter_req=01` in one cycle → `incr=1` and `grant_gate=0` two cycles later; `count=1`, `empty=0`; no other strobe.
- From `count=3`, `rr=0`: `enter_req=11` and `exit_req=10` in the same cycle → `decr` (gate 1), then `incr` (gate 0), then `incr` (gate 1) on three consecutive cycles; final `count=4`.
- Fill to `count=15`, then `enter_req=11` → gate 0 accepted, `reject` pulses once. After the `incr`: `count=16`, `full=1`, `entry_allow=0`. Another entry → `reject` again, `count` stays 16.
- At `count=0`, `exit_req=01` → no `decr`, `underflow=1`. With `count=1`, `exit_req=11` → exactly one `decr`, `count=0`, `underflow=1`.
- Pulse `enter_req[0]` on 5 consecutive cycles while blocked behind continuous exits → 4th/5th arrivals beyond a queue depth of 3 set `overflow`. The `incr` count equals the accepted entries.
- With 2 entries pending, assert `reset` for one cycle → no strobes afterward, `count=0`, all flags at their reset values.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Two-gate occupancy arbiter: admits entry/exit pulses into per-gate pending
// queues and serializes them into single incr/decr strobes for the lot counter.
module parking_gate_arbiter #(
    parameter int CAPACITY = 16,
    parameter int WIDTH    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       enter_req,
    input  logic [1:0]       exit_req,
    output logic             incr,
    output logic             decr,
    output logic             grant_gate,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             entry_allow,
    output logic             reject,
    output logic             underflow,
    output logic             overflow
);

    // state       | meaning
    // IDLE        | no events pending at either gate
    // SERVE_EXIT  | at least one exit pending; exits win since they free space
    // SERVE_ENTRY | exits drained, entries pending
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SERVE_EXIT  = 2'd1,
        SERVE_ENTRY = 2'd2
    } state_t;

    localparam int SW = WIDTH + 3;
    localparam logic [SW-1:0] CAP_W = SW'(CAPACITY);

    state_t          state, state_nxt;
    logic [1:0][1:0] ent_pend, ext_pend;
    logic [1:0][1:0] ent_nxt, ext_nxt;
    logic            rr;

    logic [SW-1:0]   ent_sum, ext_sum, ent_taken, ext_taken;
    logic [1:0]      ent_acc, ext_acc, ent_drop, ext_drop;
    logic            ent_rej, ext_rej;
    logic            gnt_valid, gnt_exit, gnt_gate;

    assign ent_sum = SW'(ent_pend[0]) + SW'(ent_pend[1]);
    assign ext_sum = SW'(ext_pend[0]) + SW'(ext_pend[1]);

    assign full        = (count == WIDTH'(CAPACITY));
    assign empty       = (count == '0);
    assign entry_allow = (SW'(count) + ent_sum) < CAP_W;

    // Admission runs on start-of-cycle values; the grant in this same cycle is ignored.
    always_comb begin
        ent_acc   = '0;
        ext_acc   = '0;
        ent_rej   = 1'b0;
        ext_rej   = 1'b0;
        ent_taken = '0;
        ext_taken = '0;
        for (int g = 0; g < 2; g++) begin
            if (enter_req[g]) begin
                if (SW'(count) + ent_sum + ent_taken < CAP_W) begin
                    ent_acc[g] = 1'b1;
                    ent_taken  = ent_taken + SW'(1);
                end else begin
                    ent_rej = 1'b1;
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            if (exit_req[g]) begin
                if (SW'(count) >= ext_sum + ext_taken + SW'(1)) begin
                    ext_acc[g] = 1'b1;
                    ext_taken  = ext_taken + SW'(1);
                end else begin
                    ext_rej = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_exit  = 1'b0;
        gnt_gate  = 1'b0;
        case (state)
            SERVE_EXIT: begin
                gnt_valid = 1'b1;
                gnt_exit  = 1'b1;
                gnt_gate  = (ext_pend[rr] != 2'd0) ? rr : ~rr;
            end
            SERVE_ENTRY: begin
                gnt_valid = 1'b1;
                gnt_gate  = (ent_pend[rr] != 2'd0) ? rr : ~rr;
            end
            default: ;
        endcase
    end

    // A full queue drops new arrivals even when it is also granted this cycle.
    always_comb begin
        ent_nxt = ent_pend;
        ext_nxt = ext_pend;
        for (int g = 0; g < 2; g++) begin
            ent_drop[g] = ent_acc[g] && (ent_pend[g] == 2'd3);
            ext_drop[g] = ext_acc[g] && (ext_pend[g] == 2'd3);
            if (ent_acc[g] && !ent_drop[g])
                ent_nxt[g] = ent_nxt[g] + 2'd1;
            if (ext_acc[g] && !ext_drop[g])
                ext_nxt[g] = ext_nxt[g] + 2'd1;
            if (gnt_valid && !gnt_exit && gnt_gate == 1'(g))
                ent_nxt[g] = ent_nxt[g] - 2'd1;
            if (gnt_valid && gnt_exit && gnt_gate == 1'(g))
                ext_nxt[g] = ext_nxt[g] - 2'd1;
        end
        if (ext_nxt != '0)
            state_nxt = SERVE_EXIT;
        else if (ent_nxt != '0)
            state_nxt = SERVE_ENTRY;
        else
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ent_pend   <= '0;
            ext_pend   <= '0;
            rr         <= 1'b0;
            incr       <= 1'b0;
            decr       <= 1'b0;
            grant_gate <= 1'b0;
            count      <= '0;
            reject     <= 1'b0;
            underflow  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ent_pend <= ent_nxt;
            ext_pend <= ext_nxt;
            incr     <= gnt_valid && !gnt_exit;
            decr     <= gnt_valid && gnt_exit;
            if (gnt_valid) begin
                grant_gate <= gnt_gate;
                rr         <= ~gnt_gate;
                count      <= gnt_exit ? count - WIDTH'(1) : count + WIDTH'(1);
            end
            reject    <= ent_rej;
            underflow <= underflow | ext_rej;
            overflow  <= overflow | (|ent_drop) | (|ext_drop);
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: vector table, directed corner sequences and
// a randomized run against a queue-level reference model of the lot.
module tb_parking_gate_arbiter;

    localparam int CAP = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] enter_req, exit_req;
    logic       incr, decr, grant_gate, full, empty, entry_allow;
    logic       reject, underflow, overflow;
    logic [4:0] count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    int m_count, m_rr, m_gate;
    int m_eq[2], m_xq[2];
    bit m_incr, m_decr, m_rej, m_unf, m_ovf;

    typedef struct {
        logic [1:0] en;
        logic [1:0] ex;
        logic       e_incr;
        logic       e_decr;
        logic       e_gate;
        logic [4:0] e_count;
        logic       e_rej;
    } vec_t;

    vec_t tbl[11];

    parking_gate_arbiter #(.CAPACITY(16), .WIDTH(5)) dut (
        .clk(clk), .reset(reset), .enter_req(enter_req), .exit_req(exit_req),
        .incr(incr), .decr(decr), .grant_gate(grant_gate), .count(count),
        .full(full), .empty(empty), .entry_allow(entry_allow), .reject(reject),
        .underflow(underflow), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_step(input logic [1:0] en, input logic [1:0] ex, input logic rst);
        int se, sx, acc, g_sel;
        bit is_exit;
        int add_e[2], add_x[2];
        if (rst) begin
            m_count = 0; m_rr = 0; m_gate = 0;
            m_eq = '{0, 0}; m_xq = '{0, 0};
            m_incr = 0; m_decr = 0; m_rej = 0; m_unf = 0; m_ovf = 0;
            return;
        end
        se = m_eq[0] + m_eq[1];
        sx = m_xq[0] + m_xq[1];
        add_e = '{0, 0}; add_x = '{0, 0};
        m_rej = 0;
        acc = 0;
        for (int g = 0; g < 2; g++)
            if (en[g]) begin
                if (m_count + se + acc < CAP) begin
                    acc++;
                    if (m_eq[g] == 3) m_ovf = 1; else add_e[g] = 1;
                end else m_rej = 1;
            end
        acc = 0;
        for (int g = 0; g < 2; g++)
            if (ex[g]) begin
                if (m_count - sx - acc >= 1) begin
                    acc++;
                    if (m_xq[g] == 3) m_ovf = 1; else add_x[g] = 1;
                end else m_unf = 1;
            end
        g_sel = -1;
        is_exit = 0;
        if (sx > 0) begin
            is_exit = 1;
            g_sel = (m_xq[m_rr] > 0) ? m_rr : 1 - m_rr;
        end else if (se > 0) begin
            g_sel = (m_eq[m_rr] > 0) ? m_rr : 1 - m_rr;
        end
        for (int g = 0; g < 2; g++) begin
            m_eq[g] += add_e[g];
            m_xq[g] += add_x[g];
        end
        m_incr = 0; m_decr = 0;
        if (g_sel >= 0) begin
            if (is_exit) begin m_xq[g_sel]--; m_count--; m_decr = 1; end
            else         begin m_eq[g_sel]--; m_count++; m_incr = 1; end
            m_gate = g_sel;
            m_rr = 1 - g_sel;
        end
    endtask

    task automatic model_check();
        logic [13:0] got, exp;
        got = {incr, decr, grant_gate, count, full, empty, entry_allow, reject, underflow, overflow};
        exp = {m_incr, m_decr, 1'(m_gate), 5'(m_count), m_count == CAP, m_count == 0,
               (m_count + m_eq[0] + m_eq[1]) < CAP, m_rej, m_unf, m_ovf};
        chk("model outputs", 32'(got), 32'(exp));
    endtask

    task automatic step(input logic [1:0] en, input logic [1:0] ex, input logic rst);
        enter_req = en;
        exit_req  = ex;
        reset     = rst;
        @(posedge clk);
        model_step(en, ex, rst);
        #1;
        cyc++;
        enter_req = 2'b00;
        exit_req  = 2'b00;
        reset     = 1'b0;
        model_check();
    endtask

    initial begin
        int n_inc, n_dec;
        logic [1:0] ren, rex;

        tbl[0]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
        tbl[1]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0};
        tbl[2]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0};
        tbl[3]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0};
        tbl[4]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0};
        tbl[5]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0};
        tbl[6]  = '{2'b11, 2'b10, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0};
        tbl[7]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0};
        tbl[8]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0};
        tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0};
        tbl[10] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0};

        reset = 1'b1; enter_req = 2'b00; exit_req = 2'b00;
        step(2'b00, 2'b00, 1'b1);
        step(2'b00, 2'b00, 1'b1);
        chk("reset incr", incr, 0);
        chk("reset count", count, 0);
        chk("reset empty", empty, 1);
        chk("reset entry_allow", entry_allow, 1);
        chk("reset flags", {full, reject, underflow, overflow}, 0);

        // single entry latency, then exit/entry ordering from count=3, rr=0
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].ex, 1'b0);
            chk("tbl incr", incr, tbl[i].e_incr);
            chk("tbl decr", decr, tbl[i].e_decr);
            chk("tbl grant_gate", grant_gate, tbl[i].e_gate);
            chk("tbl count", count, tbl[i].e_count);
            chk("tbl reject", reject, tbl[i].e_rej);
        end

        // capacity boundary
        step(2'b00, 2'b00, 1'b1);
        repeat (15) step(2'b01, 2'b00, 1'b0);
        repeat (3) step(2'b00, 2'b00, 1'b0);
        chk("fill count", count, 15);
        step(2'b11, 2'b00, 1'b0);
        chk("cap reject", reject, 1);
        step(2'b00, 2'b00, 1'b0);
        chk("cap incr", incr, 1);
        chk("cap count", count, 16);
        chk("cap full", full, 1);
        chk("cap entry_allow", entry_allow, 0);
        chk("cap reject clears", reject, 0);
        step(2'b01, 2'b00, 1'b0);
        chk("full reject", reject, 1);
        step(2'b00, 2'b00, 1'b0);
        chk("full count holds", count, 16);
        chk("full no incr", incr, 0);

        // underflow at zero and with a single car
        step(2'b00, 2'b00, 1'b1);
        step(2'b00, 2'b01, 1'b0);
        chk("unf at zero", underflow, 1);
        n_dec = 0;
        repeat (2) begin step(2'b00, 2'b00, 1'b0); n_dec += int'(decr); end
        chk("unf no decr", n_dec, 0);
        step(2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b0);
        repeat (2) step(2'b00, 2'b00, 1'b0);
        chk("one car count", count, 1);
        chk("one car unf clear", underflow, 0);
        step(2'b00, 2'b11, 1'b0);
        chk("dual exit unf", underflow, 1);
        n_dec = 0;
        repeat (3) begin step(2'b00, 2'b00, 1'b0); n_dec += int'(decr); end
        chk("dual exit decrs", n_dec, 1);
        chk("dual exit count", count, 0);

        // queue saturation behind continuous exits
        step(2'b00, 2'b00, 1'b1);
        repeat (10) step(2'b01, 2'b00, 1'b0);
        repeat (3) step(2'b00, 2'b00, 1'b0);
        chk("pre ovf count", count, 10);
        chk("pre ovf flag", overflow, 0);
        n_inc = 0; n_dec = 0;
        for (int i = 0; i < 7; i++) begin
            step((i < 5) ? 2'b01 : 2'b00, 2'b01, 1'b0);
            n_inc += int'(incr); n_dec += int'(decr);
        end
        repeat (8) begin step(2'b00, 2'b00, 1'b0); n_inc += int'(incr); n_dec += int'(decr); end
        chk("ovf flag", overflow, 1);
        chk("ovf incr count", n_inc, 3);
        chk("ovf decr count", n_dec, 7);
        chk("ovf final count", count, 6);

        // reset discards queued entries and dominates simultaneous requests
        step(2'b11, 2'b00, 1'b0);
        step(2'b11, 2'b11, 1'b1);
        chk("rst mid incr", incr, 0);
        n_inc = 0;
        repeat (4) begin step(2'b00, 2'b00, 1'b0); n_inc += int'(incr) + int'(decr); end
        chk("rst no strobes", n_inc, 0);
        chk("rst count", count, 0);
        chk("rst flags", {empty, entry_allow, full, reject, underflow, overflow}, 6'b110000);

        // randomized run, every cycle compared to the model
        for (int i = 0; i < 3000; i++) begin
            ren = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            rex = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            step(ren, rex, $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
